// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and the
// response byte codes used by requesters.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_SENDING,
        ST_GAP
    } arb_state_e;

    localparam logic [7:0] RSP_AA = 8'hAA;
    localparam logic [7:0] RSP_CC = 8'hCC;
    localparam logic [7:0] RSP_BC = 8'hBC;
    localparam logic [7:0] RSP_11 = 8'h11;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from
// last+1, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] winner
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters: round-robin
// grant, one-shot launch, busy handshake with timeout, and an idle gap per byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       idle
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    arb_state_e                  state_q, state_d;
    logic [7:0]                  tx_data_q, tx_data_d;
    logic [IDW-1:0]              gnt_id_q, gnt_id_d;
    logic [IDW-1:0]              last_q, last_d;
    logic [TMO_W-1:0]            tmo_q, tmo_d;
    logic [GAP_W-1:0]            gap_q, gap_d;
    logic [NUM_REQ-1:0]          done_q, done_d;
    logic [NUM_REQ-1:0]          err_q, err_d;
    logic                        busy_q;

    logic                        pick_valid;
    logic [IDW-1:0]              pick_winner;
    logic [NUM_REQ-1:0][7:0]     req_bytes;
    logic [NUM_REQ-1:0]          gnt_oh;

    assign req_bytes = req_data;
    assign gnt_oh    = NUM_REQ'(1) << gnt_id_q;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_data_q <= 8'h00;
            gnt_id_q  <= '0;
            last_q    <= IDW'(NUM_REQ - 1);
            tmo_q     <= '0;
            gap_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            gnt_id_q  <= gnt_id_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= tx_busy;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        done_d    = '0;
        err_d     = '0;
        unique case (state_q)
            ST_IDLE: begin
                // A busy transmitter with no grant of ours belongs to someone else.
                if (pick_valid && !tx_busy) begin
                    state_d   = ST_LAUNCH;
                    tx_data_d = req_bytes[pick_winner];
                    gnt_id_d  = pick_winner;
                    last_d    = pick_winner;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
                tmo_d   = TMO_W'(1);
            end
            ST_WAIT_BUSY: begin
                // tmo_q counts clocks since tx_start, so err lands START_TIMEOUT after it.
                if (tx_busy) begin
                    state_d = ST_SENDING;
                end else if (tmo_q >= TMO_W'(START_TIMEOUT - 1)) begin
                    err_d   = gnt_oh;
                    state_d = ST_GAP;
                    gap_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_SENDING: begin
                if (busy_q && !tx_busy) begin
                    done_d  = gnt_oh;
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state_q == ST_LAUNCH);
        idle     = (state_q == ST_IDLE);
        tx_data  = tx_data_q;
        gnt_id   = gnt_id_q;
        done     = done_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction timeline (launch / done / err with
// cycle, id, byte) compared against a round-robin reference model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NR  = 3;
    localparam int GAP = 16;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [1:0]  gnt_id;
    logic        idle;

    logic stub_busy, ext_busy;
    assign tx_busy = stub_busy | ext_busy;

    uart_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .done     (done),
        .err      (err),
        .gnt_id   (gnt_id),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int kind;   // 0 launch, 1 done, 2 err
        int id;
        int data;
    } ev_t;

    ev_t act_q[$];
    ev_t exp_q[$];

    int stub_len, stub_cnt, m_last;
    bit stub_en;

    function automatic ev_t mk(input int c, input int k, input int i, input int d);
        ev_t e;
        e.cyc = c; e.kind = k; e.id = i; e.data = d;
        return e;
    endfunction

    function automatic int oh_idx(input logic [2:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, play requesters and transmitter.
    task automatic tick();
        int i;
        @(negedge clk);
        chk("done_err_excl", int'(done & err), 0);
        chk("done_onehot0", int'($onehot0(done)), 1);
        chk("err_onehot0", int'($onehot0(err)), 1);
        if (tx_start === 1'b1) begin
            act_q.push_back(mk(cyc, 0, int'(gnt_id), int'(tx_data)));
            req_data[8*gnt_id +: 8] = 8'($urandom);
        end
        if (|done) begin
            i = oh_idx(done);
            act_q.push_back(mk(cyc, 1, i, int'(tx_data)));
            req[i] = 1'b0;
        end
        if (|err) begin
            i = oh_idx(err);
            act_q.push_back(mk(cyc, 2, i, int'(tx_data)));
            req[i] = 1'b0;
        end
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) stub_busy = 1'b0;
        end
        if (tx_start === 1'b1 && stub_en) begin
            stub_busy = 1'b1;
            stub_cnt  = stub_len;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ext_busy = 1'b0; stub_busy = 1'b0; stub_cnt = 0;
        tick();
        rst = 1'b0;
        m_last = NR - 1;
    endtask

    // Reference: held requesters served once each in rotating order; a byte
    // launched at t ends L+1 later (done) or TMO later (err); next launch GAP+1
    // after that end.
    task automatic model_round(input int t0, input logic [2:0] mask,
                               input logic [23:0] data, input int L, input bit tmo);
        logic [2:0] pend;
        int t, fin, w, c;
        pend = mask;
        t = t0;
        while (pend != 3'b000) begin
            w = -1;
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (w < 0 && pend[c]) w = c;
            end
            exp_q.push_back(mk(t, 0, w, int'(data[8*w +: 8])));
            fin = tmo ? t + TMO : t + L + 1;
            exp_q.push_back(mk(fin, tmo ? 2 : 1, w, int'(data[8*w +: 8])));
            pend[w] = 1'b0;
            m_last  = w;
            t = fin + GAP + 1;
        end
    endtask

    task automatic start_round(input logic [2:0] mask, input logic [23:0] data,
                               input int L, input bit tmo);
        act_q.delete(); exp_q.delete();
        req_data = data; req = mask; stub_len = L; stub_en = !tmo;
        model_round(cyc + 1, mask, data, L, tmo);
    endtask

    task automatic finish_round(input string nm, input int bound);
        int k = 0;
        while (act_q.size() < exp_q.size() && k < bound) begin
            tick();
            k++;
        end
        chk({nm, "_wait"}, act_q.size(), exp_q.size());
        repeat (GAP + 4) tick();
        chk({nm, "_nev"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size()) begin
                chk($sformatf("%s_ev%0d_cyc", nm, i), act_q[i].cyc, exp_q[i].cyc);
                chk($sformatf("%s_ev%0d_kind", nm, i), act_q[i].kind, exp_q[i].kind);
                chk($sformatf("%s_ev%0d_id", nm, i), act_q[i].id, exp_q[i].id);
                chk($sformatf("%s_ev%0d_data", nm, i), act_q[i].data, exp_q[i].data);
            end
        end
        chk({nm, "_idle"}, int'(idle), 1);
    endtask

    initial begin
        req_data = '0; stub_len = 2; stub_en = 1'b1;

        do_reset();
        chk("rst_idle", int'(idle), 1);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_gnt_id", int'(gnt_id), 0);

        start_round(3'b001, {16'h0000, RSP_AA}, 40, 1'b0);
        finish_round("single", 400);

        do_reset();
        start_round(3'b111, {RSP_BC, RSP_CC, RSP_AA}, 5, 1'b0);
        finish_round("all3", 400);

        start_round(3'b010, {8'h00, RSP_11, 8'h00}, 0, 1'b1);
        finish_round("timeout", 400);

        // requester 2 drops its request while requester 0 is on the wire
        do_reset();
        act_q.delete(); exp_q.delete();
        req_data = {RSP_CC, 8'h00, RSP_11}; req = 3'b101; stub_len = 20; stub_en = 1'b1;
        model_round(cyc + 1, 3'b001, req_data, 20, 1'b0);
        repeat (6) tick();
        req[2] = 1'b0;
        finish_round("withdraw", 400);

        // reset while a byte is being sent
        do_reset();
        act_q.delete(); exp_q.delete();
        req_data = {16'h0000, RSP_AA}; req = 3'b001; stub_len = 30; stub_en = 1'b1;
        repeat (5) tick();
        chk("rstmid_launched", act_q.size(), 1);
        rst = 1'b1; req = '0; stub_busy = 1'b0; stub_cnt = 0;
        tick();
        chk("rstmid_idle", int'(idle), 1);
        chk("rstmid_tx_start", int'(tx_start), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_err", int'(err), 0);
        rst = 1'b0; m_last = NR - 1;
        repeat (40) tick();
        chk("rstmid_no_done", act_q.size(), 1);
        start_round(3'b100, {RSP_BC, 16'h0000}, 4, 1'b0);
        finish_round("after_rst", 400);

        // transmitter owned externally
        do_reset();
        act_q.delete(); exp_q.delete();
        ext_busy = 1'b1; req_data = {16'h0000, RSP_11}; req = 3'b001;
        stub_len = 3; stub_en = 1'b1;
        repeat (10) tick();
        chk("ext_busy_no_start", act_q.size(), 0);
        ext_busy = 1'b0;
        model_round(cyc + 1, 3'b001, req_data, 3, 1'b0);
        finish_round("ext_busy", 400);

        for (int r = 0; r < 12; r++) begin
            start_round(3'($urandom_range(1, 7)), 24'($urandom),
                        $urandom_range(2, 12), ($urandom_range(0, 3) == 0));
            finish_round($sformatf("rand%0d", r), 400);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
